phy_rx_demux: RTL and testbench
===============================

Name: phy_rx_demux

Overview:
Receive-side byte-to-lane demultiplexer that sits directly downstream of phy_tx. It consumes the serialized byte stream that phy_tx produces on its fastest clock and rebuilds the four 8-bit lanes (In0..In3 on the transmit side), each with its valid bit. It aligns to the stream using COM idle frames. Single clock domain: the byte clock.

Parameters:
COM_SYM, 8'hBC, K28.5 COM symbol used for frame alignment.
LOSS_FRAMES, 4, number of consecutive all-invalid frames that drops lock (range 1..15).

Ports:
clk  input  1  byte clock, rising-edge active.
reset_L  input  1  asynchronous, active-low reset.
data_in  input  8  serialized byte from phy_tx.
valid_in  input  1  data_in qualifier for this slot.
Out0  output  8  recovered lane 0 byte.
Out1  output  8  recovered lane 1 byte.
Out2  output  8  recovered lane 2 byte.
Out3  output  8  recovered lane 3 byte.
valid_out0..valid_out3  output  1 each  per-lane valid for the current Out* frame.
frame_valid  output  1  one-cycle pulse when Out*/valid_out* were updated with a data frame.
active  output  1  high while in LOCKED.

Behaviour:
- Stream format: each frame occupies 4 consecutive clk cycles, slot 0..3 = lane 0..3. Slots advance every cycle whether or not valid_in is set; an invalid byte still consumes its slot.
- Reset (reset_L=0, asynchronous): all outputs 0. state=SEEK, com_cnt=0, slot=0, loss_cnt=0, shadow registers 0. Release is synchronous to clk; the first sample is taken on the first rising edge with reset_L=1.
- SEEK: on a valid_in=1 byte equal to COM_SYM, go to ALIGN with com_cnt=1. Otherwise stay in SEEK.
- ALIGN:
  - valid COM: com_cnt++.
  - any other byte, or valid_in=0: return to SEEK with com_cnt=0.
  - on the 4th consecutive valid COM: go to LOCKED with slot=0 on the next cycle. That 4-COM run is not forwarded.
- LOCKED: active=1. The slot counter wraps 3->0.
  - Slots 0..2: capture data_in and valid_in into shadow[slot].
  - Slot 3: at that same rising edge, load Out0..Out2 and valid_out0..2 from shadow, and Out3/valid_out3 from data_in/valid_in.
  - Latency: Out* change one edge after the slot-3 byte is presented, i.e. 4 cycles after the slot-0 byte.
- frame_valid is asserted for exactly the one cycle after a slot-3 edge, except in these cases (Out*/valid_out* hold their previous values and frame_valid stays 0):
  - COM frame: all 4 bytes valid and equal to COM_SYM. This is idle and is absorbed.
  - All-invalid frame: all 4 valid bits 0.
- Mixed COM and data in one frame is forwarded as data.
- Lock loss:
  - loss_cnt increments on each all-invalid frame and clears on any frame with at least one valid byte.
  - When loss_cnt reaches LOSS_FRAMES, go to SEEK at the slot-3 edge. active drops the next cycle; Out* hold; com_cnt=0.
  - loss_cnt saturates and never wraps.
- Simultaneous events: a COM frame arriving while loss_cnt>0 clears loss_cnt, since it contains valid bytes.
- Leaving LOCKED: a partially collected frame is discarded, the shadow registers are cleared, and there is no frame_valid pulse.
- Reset mid-frame discards all state immediately, independent of clk.

Optional Feature:
PHY_RX_ERR_EN:
- When defined, adds output err_align (1 bit, reset 0).
- In LOCKED, a valid COM_SYM in slot 1..3 whose frame slot 0 was not a valid COM is a misalignment. In that case:
  - pulse err_align for one cycle at the next edge;
  - discard the partial frame;
  - go to SEEK.
- When not defined, no err_align port exists, and mid-frame COMs are treated as ordinary data bytes.

Test Plan:
- Lock and data: 4x valid BC, then FF,EE,DD,CC all valid -> after the 8th byte Out0..3=FF,EE,DD,CC, valid_out=1111, frame_valid pulses once, active=1.
- Partial valid: while locked send 55,55,77,55 with valid_in=0,0,1,0 -> Out0..3=55,55,77,55, valid_out0..3=0,0,1,0, frame_valid pulse.
- Failed alignment: BC,BC,BC,12,BC,BC,BC,BC -> stays SEEK/ALIGN through the 12, locks only after the last four BCs. No frame_valid before lock.
- Lock loss: lock, then 4 frames with valid_in=0 -> active falls after the 4th frame, Out* keep their last data, no frame_valid. Re-lock with 4x BC succeeds.
- Idle absorption and reset: lock, send A1,B2,C3,D4, then a BC frame -> a single frame_valid for the A1 frame and Out* hold through the BC frame. Assert reset_L=0 mid-frame -> all outputs 0 immediately, state SEEK.
- (PHY_RX_ERR_EN) while locked send 10,BC,20,30 -> err_align pulses, active=0, no frame_valid.

Source files
------------

// File: rtl/phy_rx_demux.sv
`default_nettype none
// ============================================================================
//  Module      : phy_rx_demux
//  Description : Receive-side byte-to-lane demultiplexer. Aligns to the
//                serialized phy_tx byte stream using runs of COM symbols, then
//                rebuilds four 8-bit lanes (plus per-lane valids) from each
//                4-slot frame. Idle COM frames and all-invalid frames are
//                absorbed. A run of LOSS_FRAMES all-invalid frames drops lock.
//  Ports       : clk, reset_L (async active-low)
//                data_in[7:0], valid_in        - serialized byte + qualifier
//                Out0..Out3[7:0], valid_out0..3 - recovered lanes
//                frame_valid                   - 1-cycle pulse per data frame
//                active                        - high while LOCKED
//                err_align                     - only with PHY_RX_ERR_EN
//  Option      : `define PHY_RX_ERR_EN adds err_align and mid-frame COM
//                misalignment detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_rx_demux #(
    parameter logic [7:0]  COM_SYM     = 8'hBC,
    parameter int unsigned LOSS_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] Out0,
    output logic [7:0] Out1,
    output logic [7:0] Out2,
    output logic [7:0] Out3,
    output logic       valid_out0,
    output logic       valid_out1,
    output logic       valid_out2,
    output logic       valid_out3,
    output logic       frame_valid,
`ifdef PHY_RX_ERR_EN
    output logic       err_align,
`endif
    output logic       active
);

    typedef enum logic [1:0] {
        ST_SEEK   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] c_LOSS_LIMIT = 4'(LOSS_FRAMES);

    state_t          r_state,   w_state_nxt;
    logic [2:0]      r_com_cnt, w_com_cnt_nxt;
    logic [1:0]      r_slot,    w_slot_nxt;
    logic [3:0]      r_loss,    w_loss_nxt;
    logic [2:0][7:0] r_sh_data, w_sh_data_nxt;
    logic [2:0]      r_sh_vld,  w_sh_vld_nxt;
    logic [3:0][7:0] r_out,     w_out_nxt;
    logic [3:0]      r_vout,    w_vout_nxt;
    logic            r_fv,      w_fv_nxt;
`ifdef PHY_RX_ERR_EN
    logic            r_err,     w_err_nxt;
`endif

    logic       w_byte_com;
    logic       w_frame_com;
    logic       w_frame_idle;
    logic       w_misalign;
    logic [3:0] w_loss_inc;

    assign w_byte_com   = valid_in && (data_in == COM_SYM);
    // Idle frame: every slot valid and carrying COM (three shadowed + live byte).
    assign w_frame_com  = (&r_sh_vld) && w_byte_com &&
                          (r_sh_data[0] == COM_SYM) &&
                          (r_sh_data[1] == COM_SYM) &&
                          (r_sh_data[2] == COM_SYM);
    assign w_frame_idle = ~(|r_sh_vld) && !valid_in;
    assign w_loss_inc   = (r_loss == 4'hF) ? r_loss : r_loss + 4'd1;

`ifdef PHY_RX_ERR_EN
    // A COM in slots 1..3 is only legal when the frame opened with a COM.
    assign w_misalign = (r_state == ST_LOCKED) && (r_slot != 2'd0) && w_byte_com &&
                        !(r_sh_vld[0] && (r_sh_data[0] == COM_SYM));
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_com_cnt_nxt = r_com_cnt;
        w_slot_nxt    = r_slot;
        w_loss_nxt    = r_loss;
        w_sh_data_nxt = r_sh_data;
        w_sh_vld_nxt  = r_sh_vld;
        w_out_nxt     = r_out;
        w_vout_nxt    = r_vout;
        w_fv_nxt      = 1'b0;
`ifdef PHY_RX_ERR_EN
        w_err_nxt     = 1'b0;
`endif
        case (r_state)
            ST_SEEK: begin
                if (w_byte_com) begin
                    w_state_nxt   = ST_ALIGN;
                    w_com_cnt_nxt = 3'd1;
                end else begin
                    w_com_cnt_nxt = 3'd0;
                end
            end
            ST_ALIGN: begin
                if (w_byte_com) begin
                    if (r_com_cnt == 3'd3) begin
                        // Fourth COM in a row: lock, next byte is slot 0.
                        w_state_nxt   = ST_LOCKED;
                        w_com_cnt_nxt = 3'd0;
                        w_slot_nxt    = 2'd0;
                        w_loss_nxt    = 4'd0;
                    end else begin
                        w_com_cnt_nxt = r_com_cnt + 3'd1;
                    end
                end else begin
                    w_state_nxt   = ST_SEEK;
                    w_com_cnt_nxt = 3'd0;
                end
            end
            ST_LOCKED: begin
                if (w_misalign) begin
`ifdef PHY_RX_ERR_EN
                    w_err_nxt     = 1'b1;
`endif
                    w_state_nxt   = ST_SEEK;
                    w_com_cnt_nxt = 3'd0;
                    w_slot_nxt    = 2'd0;
                    w_loss_nxt    = 4'd0;
                    w_sh_data_nxt = '0;
                    w_sh_vld_nxt  = '0;
                end else if (r_slot != 2'd3) begin
                    w_sh_data_nxt[r_slot] = data_in;
                    w_sh_vld_nxt[r_slot]  = valid_in;
                    w_slot_nxt            = r_slot + 2'd1;
                end else begin
                    w_slot_nxt = 2'd0;
                    if (w_frame_idle) begin
                        w_loss_nxt = w_loss_inc;
                        if (w_loss_inc >= c_LOSS_LIMIT) begin
                            w_state_nxt   = ST_SEEK;
                            w_com_cnt_nxt = 3'd0;
                            w_loss_nxt    = 4'd0;
                            w_sh_data_nxt = '0;
                            w_sh_vld_nxt  = '0;
                        end
                    end else begin
                        // Any valid byte (including a pure COM frame) proves the link is alive.
                        w_loss_nxt = 4'd0;
                        if (!w_frame_com) begin
                            w_out_nxt  = {data_in, r_sh_data[2], r_sh_data[1], r_sh_data[0]};
                            w_vout_nxt = {valid_in, r_sh_vld};
                            w_fv_nxt   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_SEEK;
                w_com_cnt_nxt = 3'd0;
                w_slot_nxt    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state   <= ST_SEEK;
            r_com_cnt <= 3'd0;
            r_slot    <= 2'd0;
            r_loss    <= 4'd0;
            r_sh_data <= '0;
            r_sh_vld  <= '0;
            r_out     <= '0;
            r_vout    <= '0;
            r_fv      <= 1'b0;
`ifdef PHY_RX_ERR_EN
            r_err     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_com_cnt <= w_com_cnt_nxt;
            r_slot    <= w_slot_nxt;
            r_loss    <= w_loss_nxt;
            r_sh_data <= w_sh_data_nxt;
            r_sh_vld  <= w_sh_vld_nxt;
            r_out     <= w_out_nxt;
            r_vout    <= w_vout_nxt;
            r_fv      <= w_fv_nxt;
`ifdef PHY_RX_ERR_EN
            r_err     <= w_err_nxt;
`endif
        end
    end

    assign Out0        = r_out[0];
    assign Out1        = r_out[1];
    assign Out2        = r_out[2];
    assign Out3        = r_out[3];
    assign valid_out0  = r_vout[0];
    assign valid_out1  = r_vout[1];
    assign valid_out2  = r_vout[2];
    assign valid_out3  = r_vout[3];
    assign frame_valid = r_fv;
    assign active      = (r_state == ST_LOCKED);
`ifdef PHY_RX_ERR_EN
    assign err_align   = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_demux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_phy_rx_demux
//  Description : Scoreboard bench for phy_rx_demux. A byte-level reference
//                model predicts every forwarded frame into a queue; a monitor
//                pops and compares whenever frame_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_rx_demux;

    localparam logic [7:0] COM         = 8'hBC;
    localparam int         LOSS_FRAMES = 4;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic [7:0] Out0, Out1, Out2, Out3;
    logic       valid_out0, valid_out1, valid_out2, valid_out3;
    logic       frame_valid;
    logic       active;
`ifdef PHY_RX_ERR_EN
    logic       err_align;
`endif

    always #5 clk = ~clk;

    phy_rx_demux #(.COM_SYM(COM), .LOSS_FRAMES(LOSS_FRAMES)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .Out0       (Out0),
        .Out1       (Out1),
        .Out2       (Out2),
        .Out3       (Out3),
        .valid_out0 (valid_out0),
        .valid_out1 (valid_out1),
        .valid_out2 (valid_out2),
        .valid_out3 (valid_out3),
        .frame_valid(frame_valid),
`ifdef PHY_RX_ERR_EN
        .err_align  (err_align),
`endif
        .active     (active)
    );

    typedef struct packed {
        logic [31:0] d;   // lane 0 in the top byte
        logic [3:0]  v;   // bit i = lane i
    } frm_t;

    frm_t q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- reference model (byte-level, spec rules) -------------
    bit          m_locked;
    int          m_run;      // consecutive valid COMs while unlocked
    int          m_pos;      // slot within the frame while locked
    int          m_loss;     // consecutive all-invalid frames
    logic [7:0]  m_fb [4];
    bit          m_fv [4];
    logic [31:0] m_held_d;
    logic [3:0]  m_held_v;
    bit          m_err;

    task automatic model_reset();
        m_locked = 0; m_run = 0; m_pos = 0; m_loss = 0;
        m_held_d = '0; m_held_v = '0; m_err = 0;
        for (int i = 0; i < 4; i++) begin m_fb[i] = '0; m_fv[i] = 0; end
    endtask

    task automatic model_step(input logic [7:0] d, input bit v);
        int   nvalid;
        bit   allcom;
        bit   mis;
        m_err = 0;
        if (!m_locked) begin
            if (v && d == COM) begin
                m_run++;
                if (m_run == 4) begin
                    m_locked = 1; m_pos = 0; m_loss = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            mis = 0;
`ifdef PHY_RX_ERR_EN
            mis = (m_pos != 0) && v && (d == COM) && !(m_fv[0] && m_fb[0] == COM);
`endif
            if (mis) begin
                m_err = 1; m_locked = 0; m_run = 0; m_pos = 0; m_loss = 0;
            end else begin
                m_fb[m_pos] = d;
                m_fv[m_pos] = v;
                if (m_pos == 3) begin
                    nvalid = 0;
                    allcom = 1;
                    for (int i = 0; i < 4; i++) begin
                        if (m_fv[i]) nvalid++;
                        if (!(m_fv[i] && m_fb[i] == COM)) allcom = 0;
                    end
                    if (nvalid == 0) begin
                        if (m_loss < 15) m_loss++;
                        if (m_loss >= LOSS_FRAMES) begin
                            m_locked = 0; m_run = 0; m_loss = 0;
                        end
                    end else begin
                        m_loss = 0;
                        if (!allcom) begin
                            m_held_d = {m_fb[0], m_fb[1], m_fb[2], m_fb[3]};
                            m_held_v = {m_fv[3], m_fv[2], m_fv[1], m_fv[0]};
                            q.push_back('{d: m_held_d, v: m_held_v});
                        end
                    end
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
        end
    endtask

    // ---------------- stimulus helpers --------------------------------------
    task automatic send(input logic [7:0] d, input bit v);
        @(negedge clk);
        data_in  = d;
        valid_in = v;
        model_step(d, v);
        @(posedge clk);
        #1;
        checks++;
        if (active !== m_locked) begin
            errors++;
            $display("FAIL active: got %b expected %b at %0t", active, m_locked, $time);
        end
        checks++;
        if ({Out0, Out1, Out2, Out3} !== m_held_d ||
            {valid_out3, valid_out2, valid_out1, valid_out0} !== m_held_v) begin
            errors++;
            $display("FAIL out_hold: got %h/%b expected %h/%b at %0t",
                     {Out0, Out1, Out2, Out3}, {valid_out3, valid_out2, valid_out1, valid_out0},
                     m_held_d, m_held_v, $time);
        end
`ifdef PHY_RX_ERR_EN
        checks++;
        if (err_align !== m_err) begin
            errors++;
            $display("FAIL err_align: got %b expected %b at %0t", err_align, m_err, $time);
        end
`endif
    endtask

    task automatic send4(input logic [31:0] d, input logic [3:0] v);
        // d[31:24] is slot 0; v[3] is slot 0's valid
        for (int i = 0; i < 4; i++) send(d[31-8*i -: 8], v[3-i]);
    endtask

    task automatic lock4();
        for (int i = 0; i < 4; i++) send(COM, 1'b1);
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if ($urandom_range(0, 5) == 0) b = COM;
        return b;
    endfunction

    // ---------------- monitor / scoreboard ----------------------------------
    always @(posedge clk) begin
        frm_t f;
        #1;
        if (reset_L && frame_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL frame_unexpected: got %h/%b expected no frame at %0t",
                         {Out0, Out1, Out2, Out3}, {valid_out3, valid_out2, valid_out1, valid_out0}, $time);
            end else begin
                f = q.pop_front();
                if ({Out0, Out1, Out2, Out3} !== f.d ||
                    {valid_out3, valid_out2, valid_out1, valid_out0} !== f.v) begin
                    errors++;
                    $display("FAIL frame_data: got %h/%b expected %h/%b at %0t",
                             {Out0, Out1, Out2, Out3}, {valid_out3, valid_out2, valid_out1, valid_out0},
                             f.d, f.v, $time);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ------------------------------------------
    initial begin
        int r;
        model_reset();
        #12;
        checks++;
        if ({Out0, Out1, Out2, Out3, valid_out0, valid_out1, valid_out2, valid_out3,
             frame_valid, active} !== '0) begin
            errors++;
            $display("FAIL reset_state: got nonzero outputs expected all 0");
        end
        @(negedge clk);
        reset_L = 1'b1;

        // Lock and first data frame
        lock4();
        send4(32'hFFEEDDCC, 4'b1111);
        checks++;
        if ({Out0, Out1, Out2, Out3} !== 32'hFFEEDDCC || active !== 1'b1) begin
            errors++;
            $display("FAIL first_frame: got %h act %b expected ffeeddcc act 1",
                     {Out0, Out1, Out2, Out3}, active);
        end

        // Partial valid: only lane 2 valid
        send4(32'h55557755, 4'b0010);

        // Lock loss, then re-lock
        for (int i = 0; i < LOSS_FRAMES; i++) send4(32'h0, 4'b0000);
        checks++;
        if (active !== 1'b0) begin
            errors++;
            $display("FAIL lock_loss: got active %b expected 0", active);
        end
        lock4();

        // Drop lock again, then a broken COM run
        for (int i = 0; i < LOSS_FRAMES; i++) send4(32'h0, 4'b0000);
        send(COM, 1); send(COM, 1); send(COM, 1); send(8'h12, 1);
        lock4();

        // Idle absorption
        send4(32'hA1B2C3D4, 4'b1111);
        send4({4{COM}}, 4'b1111);
        // Loss counter cleared by a COM frame between invalid frames
        send4(32'h0, 4'b0000);
        send4({4{COM}}, 4'b1111);
        for (int i = 0; i < LOSS_FRAMES - 1; i++) send4(32'h0, 4'b0000);
        send4(32'h01020304, 4'b1001);

`ifdef PHY_RX_ERR_EN
        send4({8'h10, COM, 8'h20, 8'h30}, 4'b1111);
        lock4();
`endif

        // Randomized section
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: lock4();
                2, 3, 4, 5: send4({rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()}, 4'($urandom));
                6, 7: send4(32'($urandom), 4'b0000);
                8: send(rnd_byte(), 1'($urandom));
                default: send4({4{COM}}, 4'($urandom_range(14, 15)));
            endcase
        end

        // Reset mid-frame
        lock4();
        send(8'h11, 1); send(8'h22, 1);
        @(negedge clk);
        #2;
        reset_L = 1'b0;
        #1;
        checks++;
        if ({Out0, Out1, Out2, Out3, valid_out0, valid_out1, valid_out2, valid_out3,
             frame_valid, active} !== '0) begin
            errors++;
            $display("FAIL async_reset: got nonzero outputs expected all 0");
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_frames: got %0d expected 0", q.size());
        end
        q.delete();
        model_reset();
        @(negedge clk);
        reset_L = 1'b1;
        send(COM, 1);
        send(8'h00, 1);
        lock4();
        send4(32'hCAFEF00D, 4'b0111);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
